axi4_write_response_merger: RTL

- Write-side completion tracker for divided AXI4 write commands; the return path of the write command divider.
- Each accepted source command is split downstream into power-of-two bursts of up to MaxDivider beats. This block accepts the same source command length, works out how many bursts that split produces, and collects that many AXI B responses.
- For each source command it emits exactly one completion carrying the aggregated response, in command order.
- Sits between the AXI master B channel and the upstream completion/status logic.

---
 rtl/axi4_write_response_merger.sv | 136 +++++++++++++
 1 files changed

// File: rtl/axi4_write_response_merger.sv
// Collects the B responses of each divided write command and emits one merged completion per command.
// Optional ERRCOUNT output enabled by AXI4_WRITE_RESPONSE_MERGER_ERRCNT_EN.
module axi4_write_response_merger #(
    parameter int InnerIFLengthWidth = 16,
    parameter int MaxDivider         = 16,
    parameter int CmdFifoDepth       = 8
) (
`ifdef AXI4_WRITE_RESPONSE_MERGER_ERRCNT_EN
    output logic [15:0]                   ERRCOUNT,
`endif
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [InnerIFLengthWidth-1:0] CMDLEN,
    input  logic                          CMDVALID,
    output logic                          CMDREADY,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic [1:0]                    BRESP,
    output logic                          DONEVALID,
    input  logic                          DONEREADY,
    output logic [1:0]                    DONERESP
);

    localparam int K  = $clog2(MaxDivider);
    localparam int CW = InnerIFLengthWidth + 1;
    localparam int AW = $clog2(CmdFifoDepth);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     mem [CmdFifoDepth];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CW-1:0]     head;
    logic [CW-1:0]     remain;
    logic [1:0]        resp;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              b_hs;

    // Full bursts of MaxDivider beats plus one power-of-two burst per set low bit
    always_comb begin
        count = CW'(CMDLEN >> K);
        for (int i = 0; i < K; i++) begin
            count = count + CW'(CMDLEN[i]);
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign CMDREADY = !full;
    assign push     = CMDVALID && !full;
    assign pop      = (state == IDLE) && !empty;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign b_hs     = BVALID && BREADY;
    assign DONERESP = resp;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= count;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            remain <= '0;
            resp   <= 2'b00;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                remain <= head;
                resp   <= 2'b00;
            end
            if (b_hs) begin
                remain <= remain - CW'(1);
                // Codes are ordered by severity, so the largest code wins
                if (BRESP > resp) begin
                    resp <= BRESP;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        BREADY     = 1'b0;
        DONEVALID  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = (head != '0) ? COLLECT : REPORT;
                end
            end
            COLLECT: begin
                BREADY = 1'b1;
                if (BVALID && remain == CW'(1)) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                DONEVALID = 1'b1;
                if (DONEREADY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef AXI4_WRITE_RESPONSE_MERGER_ERRCNT_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ERRCOUNT <= 16'h0000;
        end else if (b_hs && BRESP[1] && ERRCOUNT != 16'hFFFF) begin
            ERRCOUNT <= ERRCOUNT + 16'h0001;
        end
    end
`endif

endmodule
